// File: rtl/packet_injector.sv
// Butterfly-network packet injector: head phit with full route, contiguous payload, idle between packets.
// Optional trailing XOR check phit when PACKET_INJECTOR_CHK_EN is defined.
module packet_injector #(
  parameter int PHIT_W = 16,
  parameter int STAGES = 2,
  parameter int LEN_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  output logic                  o_req_ready,
  input  logic [2*STAGES-1:0]   i_dest,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [PHIT_W-3:0]     i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [PHIT_W-1:0]     o_phit,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int DEST_W = 2 * STAGES;
  localparam int WORD_W = PHIT_W - 2;

  // State names what is currently on o_phit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             in_pkt;
  logic             last;
  logic             accept;

  function automatic logic [PHIT_W-1:0] head_phit(input logic [DEST_W-1:0] dest);
    logic [PHIT_W-1:0] h;
    h                       = '0;
    h[PHIT_W-1 -: 2]        = 2'b11;
    h[PHIT_W-3 -: DEST_W]   = dest;
    return h;
  endfunction

  function automatic logic [PHIT_W-1:0] pay_phit(input logic [WORD_W-1:0] w);
    return {2'b10, w};
  endfunction

  assign in_pkt       = (state == HEAD) || (state == PAY);
  assign last         = in_pkt && (cnt == '0);
  assign o_data_ready = in_pkt && (cnt != '0);
  assign accept       = i_req && o_req_ready;

`ifdef PACKET_INJECTOR_CHK_EN
  logic [WORD_W-1:0] acc;
  logic              take;

  assign take        = i_data_valid && o_data_ready;
  assign o_req_ready = (state == IDLE) || (state == CHK);

  // Running XOR of the packet's payload; cleared when the next request is taken.
  always_ff @(posedge i_clk) begin
    if (accept)
      acc <= '0;
    else if (take)
      acc <= acc ^ i_data;
  end
`else
  assign o_req_ready = (state == IDLE) || last;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      o_phit <= '0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (o_data_ready) begin
        if (i_data_valid) begin
          state  <= PAY;
          cnt    <= cnt - LEN_W'(1);
          o_phit <= pay_phit(i_data);
`ifdef PACKET_INJECTOR_CHK_EN
`else
          o_done <= (cnt == LEN_W'(1));
`endif
        end else begin
          // Underrun: a stall would let downstream allocators drop the port mid-packet.
          state  <= IDLE;
          o_phit <= '0;
          o_err  <= 1'b1;
        end
      end else if (accept) begin
        state  <= HEAD;
        cnt    <= i_len;
        o_phit <= head_phit(i_dest);
`ifdef PACKET_INJECTOR_CHK_EN
`else
        o_done <= (i_len == '0);
`endif
      end
`ifdef PACKET_INJECTOR_CHK_EN
      else if (last) begin
        state  <= CHK;
        o_phit <= pay_phit(acc);
        o_done <= 1'b1;
      end
`endif
      else begin
        state  <= IDLE;
        o_phit <= '0;
      end
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Randomized scoreboard bench for packet_injector; expected phit events are queued per packet request.
// Build with PACKET_INJECTOR_CHK_EN defined to check the trailing XOR phit variant.
module tb_packet_injector;

  localparam int PW    = 16;
  localparam int ST    = 2;
  localparam int LW    = 4;
  localparam int DW    = PW - 2;
  localparam int DESTW = 2 * ST;
`ifdef PACKET_INJECTOR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_req = 1'b0;
  logic             o_req_ready;
  logic [DESTW-1:0] i_dest = '0;
  logic [LW-1:0]    i_len = '0;
  logic [DW-1:0]    i_data = '0;
  logic             i_data_valid = 1'b0;
  logic             o_data_ready;
  logic [PW-1:0]    o_phit;
  logic             o_done;
  logic             o_err;

  packet_injector #(.PHIT_W(PW), .STAGES(ST), .LEN_W(LW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_req_ready(o_req_ready),
    .i_dest(i_dest), .i_len(i_len), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_phit(o_phit), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DESTW-1:0]   dest;
    int                 len;
    int                 drop;   // words actually supplied; < len means underrun
    logic [15:0][DW-1:0] data;
  } pkt_t;

  typedef struct {
    logic [PW-1:0] phit;
    logic          done;
    logic          err;
    bit            contig;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] m_head(input logic [DESTW-1:0] d);
    return PW'((3 << (PW - 2)) + (int'(d) << (PW - 2 - DESTW)));
  endfunction

  function automatic logic [PW-1:0] m_pay(input logic [DW-1:0] w);
    return PW'((2 << DW) + int'(w));
  endfunction

  // Reference: expected observable events for one packet.
  function automatic void push_pkt(input pkt_t p, input bit head_contig);
    ev_t e;
    logic [DW-1:0] x;
    e.phit = m_head(p.dest); e.done = (p.len == 0) && !CHK; e.err = 1'b0; e.contig = head_contig;
    exp_q.push_back(e);
    x = '0;
    for (int i = 0; i < p.drop; i++) begin
      x = x ^ p.data[i];
      e.phit = m_pay(p.data[i]); e.done = !CHK && (i == p.len - 1); e.err = 1'b0; e.contig = 1'b1;
      exp_q.push_back(e);
    end
    if (p.drop < p.len) begin
      e.phit = '0; e.done = 1'b0; e.err = 1'b1; e.contig = 1'b1;
      exp_q.push_back(e);
    end else if (CHK) begin
      e.phit = m_pay(x); e.done = 1'b1; e.err = 1'b0; e.contig = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge i_clk) begin
    if (mon_en) begin
      cyc++;
      if (o_phit != '0 || o_done || o_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {o_err, o_done, 14'h0, o_phit}, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("phit", 32'(o_phit), 32'(e.phit));
          chk("done_err", {30'h0, o_done, o_err}, {30'h0, e.done, e.err});
          if (e.contig) chk("contiguous", cyc - last_cyc, 1);
          last_cyc = cyc;
        end
      end
    end
  end

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.dest = DESTW'($urandom);
    p.len  = $urandom_range((1 << LW) - 1, 0);
    for (int i = 0; i < 16; i++) p.data[i] = DW'($urandom);
    p.drop = p.len;
    if (p.len > 0 && $urandom_range(4, 0) == 0) p.drop = $urandom_range(p.len - 1, 0);
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the last driven cycle.
  task automatic send(input pkt_t p, input bit head_contig);
    int n;
    push_pkt(p, head_contig);
    i_req = 1'b1; i_dest = p.dest; i_len = LW'(p.len); i_data_valid = 1'b0;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) chk("req_ready_timeout", 32'(o_req_ready), 1);
    @(negedge i_clk);
    i_req = 1'b0; i_dest = DESTW'($urandom); i_len = LW'($urandom);
    for (int i = 0; i < p.drop; i++) begin
      i_data_valid = 1'b1; i_data = p.data[i];
      n = 0;
      while (!o_data_ready && n < 50) begin @(negedge i_clk); n++; end
      if (n >= 50) chk("data_ready_timeout", 32'(o_data_ready), 1);
      @(negedge i_clk);
    end
    i_data_valid = 1'b0; i_data = DW'($urandom);
    if (p.drop < p.len) @(negedge i_clk);
  endtask

  initial begin
    pkt_t p;
    int g;
    int n;
    #2;
    chk("rst_phit", 32'(o_phit), 0);
    chk("rst_req_ready", 32'(o_req_ready), 1);
    chk("rst_data_ready", 32'(o_data_ready), 0);
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_phit", 32'(o_phit), 0);
    chk("idle_pulses", {30'h0, o_done, o_err}, 0);
    chk("idle_req_ready", 32'(o_req_ready), 1);
    chk("idle_data_ready", 32'(o_data_ready), 0);
    mon_en = 1'b1;

    // Basic two-word packet.
    p = rand_pkt(); p.dest = 4'b1001; p.len = 2; p.drop = 2;
    p.data[0] = 14'h0123; p.data[1] = 14'h0456;
    send(p, 1'b0);
    repeat (2) @(negedge i_clk);

    // Back-to-back requests with no idle gap.
    p = rand_pkt(); p.dest = 4'b0011; p.len = 1; p.drop = 1;
    send(p, 1'b0);
    p = rand_pkt(); p.dest = 4'b1100; p.len = 0; p.drop = 0;
    send(p, 1'b1);
    repeat (2) @(negedge i_clk);

    // Underrun after the first word, then a normal packet.
    p = rand_pkt(); p.len = 3; p.drop = 1;
    send(p, 1'b0);
    p = rand_pkt(); p.len = 2; p.drop = 2;
    send(p, 1'b1);
    repeat (3) @(negedge i_clk);

    // Head-only packet.
    p = rand_pkt(); p.dest = 4'b0110; p.len = 0; p.drop = 0;
    send(p, 1'b0);
    repeat (3) @(negedge i_clk);

    // Reset in the middle of a len=5 payload.
    p = rand_pkt(); p.len = 5; p.drop = 2;
    begin
      ev_t e;
      e.phit = m_head(p.dest); e.done = 1'b0; e.err = 1'b0; e.contig = 1'b0; exp_q.push_back(e);
      for (int i = 0; i < 2; i++) begin
        e.phit = m_pay(p.data[i]); e.contig = 1'b1; exp_q.push_back(e);
      end
    end
    i_req = 1'b1; i_dest = p.dest; i_len = LW'(p.len);
    @(negedge i_clk);
    i_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_data_valid = 1'b1; i_data = p.data[i];
      @(negedge i_clk);
    end
    #2 mon_en = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("midrst_phit", 32'(o_phit), 0);
    chk("midrst_pulses", {30'h0, o_done, o_err}, 0);
    chk("midrst_req_ready", 32'(o_req_ready), 1);
    chk("midrst_data_ready", 32'(o_data_ready), 0);
    chk("midrst_drained", exp_q.size(), 0);
    exp_q.delete();
    i_data_valid = 1'b0;
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    @(negedge i_clk);
    chk("postrst_pulses", {30'h0, o_done, o_err}, 0);
    mon_en = 1'b1;
    p = rand_pkt(); p.len = 3; p.drop = 3;
    send(p, 1'b0);
    repeat (2) @(negedge i_clk);

    // Randomized traffic with random gaps and occasional underruns.
    for (int k = 0; k < 60; k++) begin
      g = $urandom_range(2, 0);
      repeat (g) @(negedge i_clk);
      p = rand_pkt();
      send(p, (g == 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge i_clk); n++; end
    repeat (3) @(negedge i_clk);
    chk("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
